// File: rtl/ifill_if.sv
// rtl/ifill_if.sv - fetch-side miss port and word-wide memory port of the instruction fill controller
interface ifill_if #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 32
);
    logic                      L2_read_en;
    logic [ADDR_W-1:0]         L2_addr_read;
    logic [32*BLOCK_WORDS-1:0] L2_block_read;
    logic                      L2_stall;
    logic                      inv;
    logic                      mem_req;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_ack;
    logic [31:0]               mem_rdata;

    modport slave (
        input  L2_read_en, L2_addr_read, inv, mem_ack, mem_rdata,
        output L2_block_read, L2_stall, mem_req, mem_addr
    );

    modport master (
        output L2_read_en, L2_addr_read, inv, mem_ack, mem_rdata,
        input  L2_block_read, L2_stall, mem_req, mem_addr
    );
endinterface

// File: rtl/ifill_ctrl.sv
// rtl/ifill_ctrl.sv - single-block instruction fill buffer refilled one 32-bit word per memory beat
module ifill_ctrl #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    ifill_if.slave bus
);
    localparam int OFF   = $clog2(BLOCK_WORDS * 4);
    localparam int BW    = OFF - 2;
    localparam int TAG_W = ADDR_W - OFF;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                              state_q;
    logic                                buf_valid_q;
    logic [TAG_W-1:0]                    buf_tag_q;
    logic [BLOCK_WORDS-1:0][31:0]        block_q;
    logic [BLOCK_WORDS-1:0][31:0]        fill_buf_q;
    logic [TAG_W-1:0]                    fill_tag_q;
    logic [BW-1:0]                       beat_q;
    logic                                stale_q;
    logic                                mem_req_q;
    logic [ADDR_W-1:0]                   mem_addr_q;

    logic [TAG_W-1:0]                    req_tag;
    logic                                hit;
    logic                                last_beat;
    logic                                redirect;
    logic [BW-1:0]                       beat_inc;
    logic [BLOCK_WORDS-1:0][31:0]        fill_blk_d;
    logic                                unused_addr_bits;

    assign req_tag          = bus.L2_addr_read[ADDR_W-1:OFF];
    assign unused_addr_bits = ^bus.L2_addr_read[OFF-1:0];
    assign hit              = buf_valid_q && (buf_tag_q == req_tag);
    assign last_beat        = &beat_q;
    assign redirect         = bus.L2_read_en && (req_tag != fill_tag_q);
    assign beat_inc         = beat_q + {{(BW-1){1'b0}}, 1'b1};

    // Final word goes straight from the bus into the installed block.
    always_comb begin
        fill_blk_d         = fill_buf_q;
        fill_blk_d[beat_q] = bus.mem_rdata;
    end

    assign bus.L2_stall      = !hit;
    assign bus.L2_block_read = block_q;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_addr      = mem_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            block_q     <= '0;
            fill_buf_q  <= '0;
            fill_tag_q  <= '0;
            beat_q      <= '0;
            stale_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            if (bus.inv) begin
                buf_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (bus.L2_read_en && !hit) begin
                        state_q    <= FILL;
                        fill_tag_q <= req_tag;
                        beat_q     <= '0;
                        stale_q    <= 1'b0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {req_tag, {BW{1'b0}}, 2'b00};
                    end
                end
                FILL: begin
                    if (bus.inv) begin
                        stale_q <= 1'b1;
                    end
                    if (bus.mem_ack) begin
                        fill_buf_q[beat_q] <= bus.mem_rdata;
                        if (last_beat) begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                            beat_q    <= '0;
                            // An inv on the final beat still poisons the block.
                            if (!(stale_q || bus.inv)) begin
                                block_q     <= fill_blk_d;
                                buf_tag_q   <= fill_tag_q;
                                buf_valid_q <= 1'b1;
                            end
                        end else if (redirect) begin
                            // Restarted block is fetched entirely after any earlier inv.
                            fill_tag_q <= req_tag;
                            beat_q     <= '0;
                            stale_q    <= bus.inv;
                            mem_addr_q <= {req_tag, {BW{1'b0}}, 2'b00};
                        end else begin
                            beat_q     <= beat_inc;
                            mem_addr_q <= {fill_tag_q, beat_inc, 2'b00};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifill_ctrl.sv
// tb/tb_ifill_ctrl.sv - directed bench for ifill_ctrl with a cycle-level reference model
module tb_ifill_ctrl;
    localparam int BWORDS = 8;
    localparam int AW     = 32;

    localparam logic [255:0] BLK_3C0 = 256'h99999999_88888888_77777777_66666666_55555555_44444444_33333333_22222222;
    localparam logic [255:0] BLK_400 = 256'hC0DE041C_C0DE0418_C0DE0414_C0DE0410_C0DE040C_C0DE0408_C0DE0404_C0DE0400;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifill_if #(.BLOCK_WORDS(BWORDS), .ADDR_W(AW)) bus ();

    ifill_ctrl #(.BLOCK_WORDS(BWORDS), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [3:0] n;
        if (a[31:5] == 27'h1E) begin
            n = 4'(a[4:2]) + 4'd2;
            return {8{n}};
        end
        return a ^ 32'hC0DE0000;
    endfunction

    assign bus.mem_rdata = mem_word(bus.mem_addr);

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks every requested beat except programmed wait states.
    int          stall_beat = -1;
    int          stall_left = 0;
    int          hold_cnt   = 0;
    logic [31:0] ack_log[$];

    always @(negedge clk) begin
        if (rst_n && bus.mem_req) begin
            if (bus.mem_addr == 32'h3C8) hold_cnt++;
            if (int'(bus.mem_addr[4:2]) == stall_beat && stall_left > 0) begin
                bus.mem_ack = 1'b0;
                stall_left--;
            end else begin
                bus.mem_ack = 1'b1;
                ack_log.push_back(bus.mem_addr);
            end
        end else begin
            bus.mem_ack = 1'b0;
        end
    end

    // Reference model: buffer contents plus the in-progress fill as tag / next word.
    logic        m_valid;
    logic [26:0] m_tag;
    logic [31:0] m_blk[BWORDS];
    logic        m_fill;
    logic        m_stale;
    logic [26:0] f_tag;
    int          f_next;
    logic [31:0] f_w[BWORDS];
    logic [26:0] rt;
    logic        mh;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_tag   = '0;
            m_fill  = 1'b0;
            m_stale = 1'b0;
            f_tag   = '0;
            f_next  = 0;
            for (int i = 0; i < BWORDS; i++) begin
                m_blk[i] = '0;
                f_w[i]   = '0;
            end
        end else begin
            rt = bus.L2_addr_read[31:5];
            mh = m_valid && (m_tag == rt);
            if (!m_fill) begin
                if (bus.L2_read_en && !mh) begin
                    m_fill  = 1'b1;
                    f_tag   = rt;
                    f_next  = 0;
                    m_stale = 1'b0;
                end
            end else begin
                if (bus.mem_ack) begin
                    f_w[f_next] = mem_word({f_tag, 5'(f_next * 4)});
                    if (f_next == BWORDS - 1) begin
                        m_fill = 1'b0;
                        f_next = 0;
                        if (!(m_stale || bus.inv)) begin
                            m_valid = 1'b1;
                            m_tag   = f_tag;
                            m_blk   = f_w;
                        end
                    end else if (bus.L2_read_en && rt != f_tag) begin
                        f_tag   = rt;
                        f_next  = 0;
                        m_stale = 1'b0;
                    end else begin
                        f_next++;
                    end
                end
                if (bus.inv) m_stale = 1'b1;
            end
            if (bus.inv) m_valid = 1'b0;
        end
    end

    logic         exp_stall;
    logic [255:0] exp_blk;

    always @(negedge clk) begin
        if (rst_n) begin
            exp_stall = !(m_valid && m_tag == bus.L2_addr_read[31:5]);
            for (int i = 0; i < BWORDS; i++) exp_blk[32*i +: 32] = m_blk[i];
            chk("model_stall", 256'(bus.L2_stall), 256'(exp_stall));
            chk("model_req", 256'(bus.mem_req), 256'(m_fill));
            if (m_fill) chk("model_addr", 256'(bus.mem_addr), 256'({f_tag, 5'(f_next * 4)}));
            chk("model_block", bus.L2_block_read, exp_blk);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hit(input string name, input int budget, output int n);
        n = 0;
        while (bus.L2_stall && n < budget) begin
            step();
            n++;
        end
        chk(name, 256'(bus.L2_stall), 256'(1'b0));
    endtask

    int n;

    initial begin
        rst_n            = 1'b0;
        bus.L2_read_en   = 1'b0;
        bus.L2_addr_read = '0;
        bus.inv          = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 256'(bus.L2_stall), 256'(1'b1));
        chk("rst_req", 256'(bus.mem_req), 256'(1'b0));
        chk("rst_block", bus.L2_block_read, 256'(0));
        rst_n = 1'b1;
        step();
        step();
        chk("idle_req", 256'(bus.mem_req), 256'(1'b0));

        // Basic fill
        ack_log.delete();
        bus.L2_addr_read = 32'h3C4;
        bus.L2_read_en   = 1'b1;
        wait_hit("s2_done", 40, n);
        chk("s2_latency", 256'(n), 256'(9));
        chk("s2_beats", 256'(ack_log.size()), 256'(8));
        for (int i = 0; i < ack_log.size() && i < 8; i++)
            chk($sformatf("s2_addr%0d", i), 256'(ack_log[i]), 256'(32'h3C0 + 32'(4 * i)));
        chk("s2_block", bus.L2_block_read, BLK_3C0);
        bus.L2_read_en = 1'b0;

        // Wait states on beat 2
        bus.inv = 1'b1;
        step();
        bus.inv = 1'b0;
        step();
        chk("s3_invalid", 256'(bus.L2_stall), 256'(1'b1));
        hold_cnt   = 0;
        stall_beat = 2;
        stall_left = 3;
        bus.L2_read_en = 1'b1;
        wait_hit("s3_done", 40, n);
        chk("s3_latency", 256'(n), 256'(12));
        chk("s3_hold", 256'(hold_cnt), 256'(4));
        chk("s3_block", bus.L2_block_read, BLK_3C0);

        // Hit, then miss to another block
        bus.L2_addr_read = 32'h3D0;
        #1;
        chk("s4_hit", 256'(bus.L2_stall), 256'(1'b0));
        step();
        step();
        chk("s4_noreq", 256'(bus.mem_req), 256'(1'b0));
        bus.L2_addr_read = 32'h400;
        #1;
        chk("s4_miss", 256'(bus.L2_stall), 256'(1'b1));
        step();
        chk("s4_req", 256'(bus.mem_req), 256'(1'b1));
        chk("s4_addr", 256'(bus.mem_addr), 256'(32'h400));
        wait_hit("s4_done", 40, n);
        chk("s4_block", bus.L2_block_read, BLK_400);

        // Redirect while beat 3 is waiting for its ack
        bus.L2_read_en = 1'b0;
        bus.inv = 1'b1;
        step();
        bus.inv = 1'b0;
        ack_log.delete();
        bus.L2_addr_read = 32'h000;
        bus.L2_read_en   = 1'b1;
        stall_beat = 3;
        stall_left = 2;
        n = 0;
        do begin
            step();
            n++;
        end while (!(bus.mem_req && bus.mem_addr == 32'h00C) && n < 20);
        chk("s5_reach_beat3", 256'(bus.mem_addr), 256'(32'h00C));
        bus.L2_addr_read = 32'h400;
        wait_hit("s5_done", 40, n);
        chk("s5_beats", 256'(ack_log.size()), 256'(12));
        if (ack_log.size() >= 5) begin
            chk("s5_last_old", 256'(ack_log[3]), 256'(32'h00C));
            chk("s5_first_new", 256'(ack_log[4]), 256'(32'h400));
        end
        chk("s5_block", bus.L2_block_read, BLK_400);

        // inv at beat 5 forces a refill
        ack_log.delete();
        bus.L2_addr_read = 32'h3C4;
        n = 0;
        do begin
            step();
            n++;
        end while (!(bus.mem_req && bus.mem_addr == 32'h3D4) && n < 20);
        chk("s6_reach_beat5", 256'(bus.mem_addr), 256'(32'h3D4));
        bus.inv = 1'b1;
        step();
        bus.inv = 1'b0;
        n = 0;
        while (ack_log.size() < 8 && n < 20) begin
            step();
            n++;
        end
        chk("s6_beats", 256'(ack_log.size()), 256'(8));
        chk("s6_stale_stall", 256'(bus.L2_stall), 256'(1'b1));
        chk("s6_stale_req", 256'(bus.mem_req), 256'(1'b0));
        step();
        chk("s6_refill_req", 256'(bus.mem_req), 256'(1'b1));
        chk("s6_refill_addr", 256'(bus.mem_addr), 256'(32'h3C0));

        // Reset in the middle of a fill
        step();
        step();
        chk("s6_mid_req", 256'(bus.mem_req), 256'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("s6_rst_req", 256'(bus.mem_req), 256'(1'b0));
        chk("s6_rst_stall", 256'(bus.L2_stall), 256'(1'b1));
        step();
        step();
        rst_n = 1'b1;
        ack_log.delete();
        step();
        chk("s6_restart_req", 256'(bus.mem_req), 256'(1'b1));
        chk("s6_restart_addr", 256'(bus.mem_addr), 256'(32'h3C0));
        wait_hit("s6_done", 40, n);
        chk("s6_block", bus.L2_block_read, BLK_3C0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ifill_ctrl.md
Name: ifill_ctrl

Overview:
Instruction-side fill controller that sits directly upstream of the fetch stage. It serves the fetch L1I miss interface (L2_read_en / L2_addr_read / L2_block_read / L2_stall). It holds a single 256-bit block buffer and refills it from a 32-bit word-wide memory port, one beat per word. Blocks are assembled little-endian, so word 0 lands in bits [31:0].

Parameters:
BLOCK_WORDS, 8, 32-bit words per block; must be a power of 2.
ADDR_W, 32, address width.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
L2_read_en  in  1  fetch requests the block containing L2_addr_read.
L2_addr_read  in  ADDR_W  byte address from fetch; only the tag bits [ADDR_W-1:OFF] are used, with OFF = log2(BLOCK_WORDS*4) = 5.
L2_block_read  out  32*BLOCK_WORDS  buffered block; word i occupies bits [32i+31:32i].
L2_stall  out  1  1 = the block for the requested address is not available.
inv  in  1  single-cycle pulse; invalidates the buffer (fence.i).
mem_req  out  1  memory word-read request.
mem_addr  out  ADDR_W  word-aligned read address.
mem_ack  in  1  memory accepts the request; mem_rdata is valid in the same cycle.
mem_rdata  in  32  read data.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, buf_valid=0, buf_tag=0, L2_block_read=0.
  - L2_stall=1, mem_req=0, mem_addr=0, beat=0, stale=0.
- Hit and stall logic:
  - hit = buf_valid && buf_tag == L2_addr_read tag. This is combinational from registered state.
  - L2_stall = !hit, regardless of L2_read_en.
  - A hit returns the block with zero added latency and issues no memory traffic.
- State IDLE:
  - Condition L2_read_en && !hit → go to FILL.
  - On that edge: fill_tag ← request tag, beat ← 0, stale ← 0, mem_req ← 1, mem_addr ← {fill_tag, beat, 2'b00}.
- State FILL:
  - mem_req stays high and mem_addr stays stable until mem_ack is sampled high. Wait states of any length are legal.
  - On each ack: word[beat] of the fill buffer ← mem_rdata; beat ← beat+1; mem_addr advances to the next word. mem_req may stay high back-to-back, one beat per cycle at best.
  - On the ack of beat BLOCK_WORDS-1:
    - mem_req ← 0.
    - If stale=0: L2_block_read ← assembled block, buf_tag ← fill_tag, buf_valid ← 1. state → IDLE.
    - If stale=1: the data is discarded and the buffer is left unchanged. state → IDLE, which immediately re-evaluates the miss.
  - Best-case fill latency: with ack on every beat, L2_stall falls in the cycle after the 8th ack edge. That is 9 cycles from the request edge.
- Redirect during FILL (the L2_addr_read tag changes from fill_tag while L2_read_en=1):
  - The in-flight beat is not cancelled; the controller waits for its ack.
  - The remaining beats are then dropped: beat ← 0, fill_tag ← new tag, and the next mem_addr is the new block's word 0.
  - No partial block is ever exposed.
- L2_read_en deasserted during FILL: the fill completes and the buffer is installed (prefetch semantics).
- inv:
  - Clears buf_valid on the next edge.
  - If it arrives during FILL, it also sets stale=1.
  - inv coinciding with the final ack counts as stale.
- Reset mid-fill: mem_req drops asynchronously and all progress is lost. The memory side must tolerate an abandoned request. After release, the fill restarts from beat 0.
- Wrap-around: the beat counter is OFF-2 bits wide and wraps only on completion. The address never carries into the tag.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles → L2_stall=1, mem_req=0, L2_block_read=0. Release with L2_read_en=0 → mem_req stays 0.
2. Basic fill: L2_read_en=1, addr=0x3C4; mem acks every cycle with data 0x22222222…0x99999999.
   - mem_addr must step 0x3C0,0x3C4,…,0x3DC.
   - One cycle after the 8th ack: L2_stall=0 and L2_block_read=256'h99999999_88888888_…_22222222.
3. Wait states: same as scenario 2, but mem_ack is held low 3 cycles on beat 2 → mem_addr holds 0x3C8 and mem_req stays 1 for those 3 cycles. The final block is identical to scenario 2.
4. Hit: after scenario 2, addr=0x3D0 → L2_stall=0 in the same cycle and mem_req stays 0. Then addr=0x400 → L2_stall=1 and a fill starts at 0x400.
5. Redirect: during a fill of 0x000, change addr to 0x400 after beat 3's ack is pending.
   - Beat 3 completes at 0x00C; the next mem_addr is 0x400.
   - L2_stall stays 1 until block 0x400 is installed; buf_tag then matches 0x400.
6. inv during fill / reset mid-fill:
   - Pulse inv at beat 5 → after the 8th ack L2_stall stays 1 and a refill restarts at word 0.
   - Separately, assert rst_n=0 with mem_req=1 → mem_req=0 immediately; after release the fill restarts at word 0.
